// File: rtl/mem_addr_skew_pkg.sv
// Shared sizing defaults and lane-packing helper for the skew stage and the
// master memory controller.
package mem_addr_skew_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 8;
    localparam int unsigned DEF_WIDTH_HEIGHT = 16;

    // Lane i of a flat address vector lives at [lane_lsb(i, aw) +: aw].
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned aw);
        return lane * aw;
    endfunction

endpackage

// File: rtl/mem_addr_skew_if.sv
// Flat per-column address bus between the memory controller and the skew stage.
interface mem_addr_skew_if
    import mem_addr_skew_pkg::*;
#(
    parameter int unsigned addr_width   = DEF_ADDR_WIDTH,
    parameter int unsigned width_height = DEF_WIDTH_HEIGHT
);

    logic                                flush;
    logic [addr_width*width_height-1:0]  in_addr;
    logic [width_height-1:0]             in_en;
    logic                                in_done;
    logic [addr_width*width_height-1:0]  out_addr;
    logic [width_height-1:0]             out_en;
    logic                                done;
    logic                                busy;

    modport master (
        output flush, in_addr, in_en, in_done,
        input  out_addr, out_en, done, busy
    );

    modport slave (
        input  flush, in_addr, in_en, in_done,
        output out_addr, out_en, done, busy
    );

endinterface

// File: rtl/mem_addr_skew_delay_line.sv
// One column lane: a depth-stage {en, addr} delay line; addr is held at zero
// in any stage whose en is low.
module skew_delay_line #(
    parameter int unsigned depth = 1,
    parameter int unsigned width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             d_en,
    input  logic [width-1:0] d_addr,
    output logic             q_en,
    output logic [width-1:0] q_addr,
    output logic             any_en
);

    logic [depth-1:0] en_sr;
    logic [width-1:0] addr_sr [depth];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_sr <= '0;
            for (int unsigned i = 0; i < depth; i++) addr_sr[i] <= '0;
        end else if (flush) begin
            en_sr <= '0;
            for (int unsigned i = 0; i < depth; i++) addr_sr[i] <= '0;
        end else begin
            en_sr[0]   <= d_en;
            addr_sr[0] <= d_en ? d_addr : '0;
            for (int unsigned i = 1; i < depth; i++) begin
                en_sr[i]   <= en_sr[i-1];
                addr_sr[i] <= addr_sr[i-1];
            end
        end
    end

    assign q_en   = en_sr[depth-1];
    assign q_addr = addr_sr[depth-1];
    assign any_en = |en_sr;

endmodule

// File: rtl/mem_addr_skew.sv
// Diagonal skew stage: lane i is delayed by i+1 cycles so columns enter the
// systolic array on a wavefront; done is retimed to the last skewed beat.
module mem_addr_skew
    import mem_addr_skew_pkg::*;
#(
    parameter int unsigned addr_width   = DEF_ADDR_WIDTH,
    parameter int unsigned width_height = DEF_WIDTH_HEIGHT
) (
    input  logic           clk,
    input  logic           reset,
    mem_addr_skew_if.slave bus
);

    logic                  lane_en   [width_height];
    logic [addr_width-1:0] lane_addr [width_height];
    logic                  lane_busy [width_height];
    logic [width_height-1:0] done_sr;

    for (genvar i = 0; i < width_height; i++) begin : g_lane
        skew_delay_line #(
            .depth (i + 1),
            .width (addr_width)
        ) u_line (
            .clk    (clk),
            .reset  (reset),
            .flush  (bus.flush),
            .d_en   (bus.in_en[i]),
            .d_addr (bus.in_addr[lane_lsb(i, addr_width) +: addr_width]),
            .q_en   (lane_en[i]),
            .q_addr (lane_addr[i]),
            .any_en (lane_busy[i])
        );
    end

    always_comb begin
        bus.out_en   = '0;
        bus.out_addr = '0;
        bus.busy     = 1'b0;
        for (int unsigned i = 0; i < width_height; i++) begin
            bus.out_en[i] = lane_en[i];
            bus.out_addr[lane_lsb(i, addr_width) +: addr_width] = lane_addr[i];
            bus.busy = bus.busy | lane_busy[i];
        end
    end

    // Same depth as the longest lane, so done lines up with lane width_height-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_sr <= '0;
        end else if (bus.flush) begin
            done_sr <= '0;
        end else begin
            done_sr[0] <= bus.in_done;
            for (int unsigned i = 1; i < width_height; i++) done_sr[i] <= done_sr[i-1];
        end
    end

    assign bus.done = done_sr[width_height-1];

endmodule

// File: tb/tb_mem_addr_skew.sv
// Directed bench for mem_addr_skew at width_height=4, addr_width=8.
module tb_mem_addr_skew;

    typedef struct {
        logic        flush;
        logic [3:0]  en;
        logic [31:0] addr;
        logic        in_done;
        logic [3:0]  x_en;
        logic [31:0] x_addr;
        logic        x_done;
        logic        x_busy;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    vec_t vq[$];

    mem_addr_skew_if #(.addr_width(8), .width_height(4)) bus ();

    mem_addr_skew #(.addr_width(8), .width_height(4)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] pk(input logic [7:0] a3, input logic [7:0] a2,
                                       input logic [7:0] a1, input logic [7:0] a0);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [31:0] rep(input logic [7:0] a);
        return {a, a, a, a};
    endfunction

    function automatic void add(input logic fl, input logic [3:0] en, input logic [31:0] a,
                                input logic dn, input logic [3:0] xe, input logic [31:0] xa,
                                input logic xd, input logic xb);
        vec_t v;
        v.flush = fl; v.en = en; v.addr = a; v.in_done = dn;
        v.x_en = xe; v.x_addr = xa; v.x_done = xd; v.x_busy = xb;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".out_en"},   {28'd0, bus.out_en}, 32'd0);
        chk({nm, ".out_addr"}, bus.out_addr, 32'd0);
        chk({nm, ".done"},     {31'd0, bus.done}, 32'd0);
        chk({nm, ".busy"},     {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic drive(input logic fl, input logic [3:0] en, input logic [31:0] a, input logic dn);
        bus.flush   = fl;
        bus.in_en   = en;
        bus.in_addr = a;
        bus.in_done = dn;
    endtask

    // Record k: outputs expected during cycle k, inputs presented in cycle k.
    task automatic run_vec(input string nm);
        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            chk($sformatf("%s[%0d].out_en", nm, k),   {28'd0, bus.out_en}, {28'd0, vq[k].x_en});
            chk($sformatf("%s[%0d].out_addr", nm, k), bus.out_addr, vq[k].x_addr);
            chk($sformatf("%s[%0d].done", nm, k),     {31'd0, bus.done}, {31'd0, vq[k].x_done});
            chk($sformatf("%s[%0d].busy", nm, k),     {31'd0, bus.busy}, {31'd0, vq[k].x_busy});
            drive(vq[k].flush, vq[k].en, vq[k].addr, vq[k].in_done);
        end
        vq.delete();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        drive(1'b0, 4'h0, 32'd0, 1'b0);

        // Reset held with inputs toggling: everything stays at zero.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk_idle($sformatf("rst_hold[%0d]", c));
            drive(1'($urandom_range(0, 1)), 4'($urandom), $urandom, 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Single beat captured at the first edge after release.
        add(0, 4'hF, rep(8'h10), 0, 4'h0, 32'd0, 0, 0);
        add(0, 4'h0, 32'd0, 0, 4'h1, pk(8'h00, 8'h00, 8'h00, 8'h10), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h2, pk(8'h00, 8'h00, 8'h10, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h4, pk(8'h00, 8'h10, 8'h00, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h8, pk(8'h10, 8'h00, 8'h00, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h0, 32'd0, 0, 0);
        run_vec("single");

        // Three-row stream, done follows; flush then clears the done pipe.
        add(0, 4'hF, rep(8'h20), 0, 4'h0, 32'd0, 0, 0);
        add(0, 4'hF, rep(8'h21), 0, 4'h1, pk(8'h00, 8'h00, 8'h00, 8'h20), 0, 1);
        add(0, 4'hF, rep(8'h22), 0, 4'h3, pk(8'h00, 8'h00, 8'h20, 8'h21), 0, 1);
        add(0, 4'h0, 32'd0,      1, 4'h7, pk(8'h00, 8'h20, 8'h21, 8'h22), 0, 1);
        add(0, 4'h0, 32'd0,      1, 4'hE, pk(8'h20, 8'h21, 8'h22, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0,      1, 4'hC, pk(8'h21, 8'h22, 8'h00, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0,      1, 4'h8, pk(8'h22, 8'h00, 8'h00, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0,      1, 4'h0, 32'd0, 1, 0);
        add(1, 4'h0, 32'd0,      0, 4'h0, 32'd0, 1, 0);
        add(0, 4'h0, 32'd0,      0, 4'h0, 32'd0, 0, 0);
        run_vec("stream");

        // Only lanes 0-1 enabled; lanes 2-3 carry nonzero addresses that must not leak.
        add(0, 4'h3, pk(8'h33, 8'h32, 8'h31, 8'h30), 0, 4'h0, 32'd0, 0, 0);
        add(0, 4'h3, pk(8'h43, 8'h42, 8'h41, 8'h40), 0, 4'h1, pk(8'h00, 8'h00, 8'h00, 8'h30), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h3, pk(8'h00, 8'h00, 8'h31, 8'h40), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h2, pk(8'h00, 8'h00, 8'h41, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h0, 32'd0, 0, 0);
        add(0, 4'h0, 32'd0, 0, 4'h0, 32'd0, 0, 0);
        run_vec("partial");

        // Flush in the third row: row 0x52 is dropped, row 0x53 skews normally.
        add(0, 4'hF, rep(8'h50), 0, 4'h0, 32'd0, 0, 0);
        add(0, 4'hF, rep(8'h51), 0, 4'h1, pk(8'h00, 8'h00, 8'h00, 8'h50), 0, 1);
        add(1, 4'hF, rep(8'h52), 0, 4'h3, pk(8'h00, 8'h00, 8'h50, 8'h51), 0, 1);
        add(0, 4'hF, rep(8'h53), 0, 4'h0, 32'd0, 0, 0);
        add(0, 4'h0, 32'd0, 0, 4'h1, pk(8'h00, 8'h00, 8'h00, 8'h53), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h2, pk(8'h00, 8'h00, 8'h53, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h4, pk(8'h00, 8'h53, 8'h00, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h8, pk(8'h53, 8'h00, 8'h00, 8'h00), 0, 1);
        add(0, 4'h0, 32'd0, 0, 4'h0, 32'd0, 0, 0);
        run_vec("flush");

        // Async reset three cycles into a stream, dropped between edges.
        @(negedge clk); drive(0, 4'hF, rep(8'h70), 0);
        @(negedge clk); drive(0, 4'hF, rep(8'h71), 0);
        @(negedge clk); drive(0, 4'hF, rep(8'h72), 0);
        @(negedge clk);
        chk("arst_pre.out_en",   {28'd0, bus.out_en}, 32'h0000_0007);
        chk("arst_pre.out_addr", bus.out_addr, pk(8'h00, 8'h70, 8'h71, 8'h72));
        drive(0, 4'hF, rep(8'h73), 0);
        #2 reset_n = 1'b0;
        #1 chk_idle("arst_now");
        @(negedge clk);
        drive(0, 4'h0, 32'd0, 0);
        chk_idle("arst_held");
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk_idle($sformatf("arst_after[%0d]", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
